// File: rtl/sy_dcache_mem_rr.sv
// sy_dcache_mem_rr: L1 dcache tag/state/data storage shared by NUM_PORT
// requesters via independent round-robin tag and data arbiters.
// Ports: clk_i, rst_i (async, active-low).
//   flush_req_i/flush_busy_o/flush_done_o: set-walking invalidate.
//   cl_valid_o: live valid bits, bit set*WAY_NUM+way.
//   tag_*: req/gnt, write (tag/valid/state) or read with hit compare,
//          per-port rsp_valid one cycle after a read grant.
//   data_*: req/gnt, byte-strobed write or read of all ways,
//           per-port rsp_valid one cycle after a read grant.
module sy_dcache_mem_rr #(
    parameter int NUM_PORT = 2,
    parameter int WAY_NUM  = 4,
    parameter int SET_NUM  = 64,
    parameter int TAG_WTH  = 20,
    parameter int DATA_WTH = 64,
    parameter int BEATS    = 8,
    localparam int SET_W   = $clog2(SET_NUM),
    localparam int BEAT_W  = $clog2(BEATS),
    localparam int ADDR_W  = SET_W + BEAT_W,
    localparam int STRB_W  = DATA_WTH / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_req_i,
    output logic                          flush_busy_o,
    output logic                          flush_done_o,
    output logic [SET_NUM*WAY_NUM-1:0]    cl_valid_o,
    input  logic [NUM_PORT-1:0]           tag_req_i,
    output logic [NUM_PORT-1:0]           tag_gnt_o,
    input  logic [NUM_PORT-1:0]           tag_we_i,
    input  logic [NUM_PORT*SET_W-1:0]     tag_set_i,
    input  logic [NUM_PORT*WAY_NUM-1:0]   tag_way_en_i,
    input  logic [NUM_PORT*TAG_WTH-1:0]   tag_wtag_i,
    input  logic [NUM_PORT-1:0]           tag_wvalid_i,
    input  logic [NUM_PORT*2-1:0]         tag_wstate_i,
    input  logic [NUM_PORT*TAG_WTH-1:0]   tag_cmp_i,
    output logic [NUM_PORT-1:0]           tag_rsp_valid_o,
    output logic [WAY_NUM*TAG_WTH-1:0]    tag_rtag_o,
    output logic [WAY_NUM-1:0]            tag_rvalid_o,
    output logic [WAY_NUM*2-1:0]          tag_rstate_o,
    output logic [WAY_NUM-1:0]            tag_hit_o,
    input  logic [NUM_PORT-1:0]           data_req_i,
    output logic [NUM_PORT-1:0]           data_gnt_o,
    input  logic [NUM_PORT-1:0]           data_we_i,
    input  logic [NUM_PORT*ADDR_W-1:0]    data_addr_i,
    input  logic [NUM_PORT*WAY_NUM-1:0]   data_way_en_i,
    input  logic [NUM_PORT*DATA_WTH-1:0]  data_wdata_i,
    input  logic [NUM_PORT*STRB_W-1:0]    data_wstrb_i,
    output logic [NUM_PORT-1:0]           data_rsp_valid_o,
    output logic [WAY_NUM*DATA_WTH-1:0]   data_rdata_o
);

    localparam int P_W   = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
    localparam int LINES = SET_NUM * BEATS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } fl_state_e;

    fl_state_e        state_q, state_d;
    logic [SET_W-1:0] cnt_q, cnt_d;
    logic             busy, walk, done, arb_en;

    logic [TAG_WTH-1:0]              tag_q [SET_NUM][WAY_NUM];
    logic [1:0]                      st_q  [SET_NUM][WAY_NUM];
    logic [SET_NUM-1:0][WAY_NUM-1:0] vld_q;
    logic [DATA_WTH-1:0]             dat_q [WAY_NUM][LINES];

    logic [P_W-1:0]      tptr_q, dptr_q;
    logic [NUM_PORT-1:0] tgnt, dgnt;
    logic [P_W-1:0]      tidx, didx;

    // Round-robin pick: first requester at or after ptr
    function automatic logic [NUM_PORT-1:0] rr_pick(
        input logic [NUM_PORT-1:0] req,
        input logic [P_W-1:0]      ptr
    );
        logic [NUM_PORT-1:0] g;
        logic                found;
        int                  p;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_PORT; k++) begin
            p = (int'(ptr) + k) % NUM_PORT;
            if (!found && req[p]) begin
                g[p]  = 1'b1;
                found = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [P_W-1:0] enc(
        input logic [NUM_PORT-1:0] oh
    );
        logic [P_W-1:0] i;
        i = '0;
        for (int k = 0; k < NUM_PORT; k++) begin
            if (oh[k]) begin
                i = P_W'(k);
            end
        end
        return i;
    endfunction

    function automatic logic [P_W-1:0] nxt(
        input logic [P_W-1:0] i
    );
        return (int'(i) == NUM_PORT - 1) ? '0 : i + P_W'(1);
    endfunction

    // ---------------- flush FSM ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (flush_req_i) begin
                    state_d = WALK;
                    cnt_d   = '0;
                end
            end
            WALK: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SET_W'(SET_NUM - 1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        walk = 1'b0;
        done = 1'b0;
        unique case (state_q)
            IDLE: ;
            WALK: begin
                busy = 1'b1;
                walk = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign flush_busy_o = busy;
    assign flush_done_o = done;
    assign cl_valid_o   = vld_q;

    // ---------------- arbitration ----------------
    // A flush request in IDLE blocks grants in that same cycle.
    assign arb_en = (state_q == IDLE) && !flush_req_i;
    assign tgnt   = arb_en ? rr_pick(tag_req_i, tptr_q) : '0;
    assign dgnt   = arb_en ? rr_pick(data_req_i, dptr_q) : '0;
    assign tidx   = enc(tgnt);
    assign didx   = enc(dgnt);

    assign tag_gnt_o  = tgnt;
    assign data_gnt_o = dgnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tptr_q <= '0;
            dptr_q <= '0;
        end else begin
            if (|tgnt) tptr_q <= nxt(tidx);
            if (|dgnt) dptr_q <= nxt(didx);
        end
    end

    // ---------------- granted request fields ----------------
    logic               t_wr, t_rd;
    logic [SET_W-1:0]   t_set;
    logic [WAY_NUM-1:0] t_way;
    logic [TAG_WTH-1:0] t_wtag, t_cmp;
    logic               t_wvld;
    logic [1:0]         t_wst;

    assign t_wr   = (|tgnt) && tag_we_i[tidx];
    assign t_rd   = (|tgnt) && !tag_we_i[tidx];
    assign t_set  = tag_set_i[tidx*SET_W +: SET_W];
    assign t_way  = tag_way_en_i[tidx*WAY_NUM +: WAY_NUM];
    assign t_wtag = tag_wtag_i[tidx*TAG_WTH +: TAG_WTH];
    assign t_cmp  = tag_cmp_i[tidx*TAG_WTH +: TAG_WTH];
    assign t_wvld = tag_wvalid_i[tidx];
    assign t_wst  = tag_wstate_i[tidx*2 +: 2];

    logic                d_wr, d_rd;
    logic [ADDR_W-1:0]   d_addr;
    logic [WAY_NUM-1:0]  d_way;
    logic [DATA_WTH-1:0] d_wdata;
    logic [STRB_W-1:0]   d_wstrb;

    assign d_wr    = (|dgnt) && data_we_i[didx];
    assign d_rd    = (|dgnt) && !data_we_i[didx];
    assign d_addr  = data_addr_i[didx*ADDR_W +: ADDR_W];
    assign d_way   = data_way_en_i[didx*WAY_NUM +: WAY_NUM];
    assign d_wdata = data_wdata_i[didx*DATA_WTH +: DATA_WTH];
    assign d_wstrb = data_wstrb_i[didx*STRB_W +: STRB_W];

    // ---------------- tag / state / valid store ----------------
    // Walk and tag writes never coincide: no grants while busy.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_q <= '0;
            for (int s = 0; s < SET_NUM; s++) begin
                for (int w = 0; w < WAY_NUM; w++) begin
                    tag_q[s][w] <= '0;
                    st_q[s][w]  <= '0;
                end
            end
        end else if (walk) begin
            vld_q[cnt_q] <= '0;
            for (int w = 0; w < WAY_NUM; w++) begin
                st_q[cnt_q][w] <= '0;
            end
        end else if (t_wr) begin
            for (int w = 0; w < WAY_NUM; w++) begin
                if (t_way[w]) begin
                    tag_q[t_set][w] <= t_wtag;
                    st_q[t_set][w]  <= t_wst;
                    vld_q[t_set][w] <= t_wvld;
                end
            end
        end
    end

    logic [WAY_NUM-1:0][TAG_WTH-1:0] rtag_q;
    logic [WAY_NUM-1:0][1:0]         rstate_q;
    logic [WAY_NUM-1:0]              rvld_q, hit_q;
    logic [NUM_PORT-1:0]             trsp_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rtag_q   <= '0;
            rstate_q <= '0;
            rvld_q   <= '0;
            hit_q    <= '0;
            trsp_q   <= '0;
        end else begin
            trsp_q <= t_rd ? tgnt : '0;
            if (t_rd) begin
                for (int w = 0; w < WAY_NUM; w++) begin
                    rtag_q[w]   <= tag_q[t_set][w];
                    rvld_q[w]   <= t_way[w] & vld_q[t_set][w];
                    rstate_q[w] <= t_way[w] ? st_q[t_set][w] : 2'b00;
                    hit_q[w]    <= t_way[w] & vld_q[t_set][w]
                                   & (tag_q[t_set][w] == t_cmp);
                end
            end
        end
    end

    assign tag_rsp_valid_o = trsp_q;
    assign tag_rtag_o      = rtag_q;
    assign tag_rvalid_o    = rvld_q;
    assign tag_rstate_o    = rstate_q;
    assign tag_hit_o       = hit_q;

    // ---------------- data store ----------------
    // SRAM-like array: contents are not reset.
    always_ff @(posedge clk_i) begin
        if (d_wr) begin
            for (int w = 0; w < WAY_NUM; w++) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (d_way[w] && d_wstrb[b]) begin
                        dat_q[w][d_addr][b*8 +: 8] <= d_wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    logic [WAY_NUM-1:0][DATA_WTH-1:0] rdata_q;
    logic [NUM_PORT-1:0]              drsp_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
            drsp_q  <= '0;
        end else begin
            drsp_q <= d_rd ? dgnt : '0;
            if (d_rd) begin
                for (int w = 0; w < WAY_NUM; w++) begin
                    rdata_q[w] <= dat_q[w][d_addr];
                end
            end
        end
    end

    assign data_rsp_valid_o = drsp_q;
    assign data_rdata_o     = rdata_q;

endmodule

// File: tb/tb_sy_dcache_mem_rr.sv
// tb_sy_dcache_mem_rr: scoreboard bench for sy_dcache_mem_rr.
// Reference model works on plain arrays, queues and integers.
module tb_sy_dcache_mem_rr;

    localparam int NP = 2;
    localparam int WN = 4;
    localparam int SN = 64;
    localparam int TW = 20;
    localparam int DW = 64;
    localparam int BT = 8;
    localparam int SW = $clog2(SN);
    localparam int BW = $clog2(BT);
    localparam int AW = SW + BW;
    localparam int SB = DW / 8;
    localparam int LN = SN * BT;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    logic              flush_req_i, flush_busy_o, flush_done_o;
    logic [SN*WN-1:0]  cl_valid_o;
    logic [NP-1:0]     tag_req_i, tag_gnt_o, tag_we_i, tag_wvalid_i;
    logic [NP*SW-1:0]  tag_set_i;
    logic [NP*WN-1:0]  tag_way_en_i;
    logic [NP*TW-1:0]  tag_wtag_i, tag_cmp_i;
    logic [NP*2-1:0]   tag_wstate_i;
    logic [NP-1:0]     tag_rsp_valid_o;
    logic [WN*TW-1:0]  tag_rtag_o;
    logic [WN-1:0]     tag_rvalid_o, tag_hit_o;
    logic [WN*2-1:0]   tag_rstate_o;
    logic [NP-1:0]     data_req_i, data_gnt_o, data_we_i;
    logic [NP*AW-1:0]  data_addr_i;
    logic [NP*WN-1:0]  data_way_en_i;
    logic [NP*DW-1:0]  data_wdata_i;
    logic [NP*SB-1:0]  data_wstrb_i;
    logic [NP-1:0]     data_rsp_valid_o;
    logic [WN*DW-1:0]  data_rdata_o;

    sy_dcache_mem_rr #(
        .NUM_PORT(NP), .WAY_NUM(WN), .SET_NUM(SN),
        .TAG_WTH(TW), .DATA_WTH(DW), .BEATS(BT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .flush_req_i(flush_req_i), .flush_busy_o(flush_busy_o),
        .flush_done_o(flush_done_o), .cl_valid_o(cl_valid_o),
        .tag_req_i(tag_req_i), .tag_gnt_o(tag_gnt_o),
        .tag_we_i(tag_we_i), .tag_set_i(tag_set_i),
        .tag_way_en_i(tag_way_en_i), .tag_wtag_i(tag_wtag_i),
        .tag_wvalid_i(tag_wvalid_i), .tag_wstate_i(tag_wstate_i),
        .tag_cmp_i(tag_cmp_i), .tag_rsp_valid_o(tag_rsp_valid_o),
        .tag_rtag_o(tag_rtag_o), .tag_rvalid_o(tag_rvalid_o),
        .tag_rstate_o(tag_rstate_o), .tag_hit_o(tag_hit_o),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
        .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_way_en_i(data_way_en_i), .data_wdata_i(data_wdata_i),
        .data_wstrb_i(data_wstrb_i), .data_rsp_valid_o(data_rsp_valid_o),
        .data_rdata_o(data_rdata_o)
    );

    // ---------------- reference model ----------------
    logic [TW-1:0] m_tag [SN][WN];
    logic [1:0]    m_st  [SN][WN];
    logic          m_vld [SN][WN];
    logic [DW-1:0] m_dat [WN][LN];
    int            t_ptr, d_ptr, fl_cnt;

    typedef struct {
        int            port;
        int            cyc;
        logic [WN-1:0] en;
        logic [WN*TW-1:0] tag;
        logic [WN-1:0] vld;
        logic [WN*2-1:0] st;
        logic [WN-1:0] hit;
    } trsp_t;

    typedef struct {
        int               port;
        int               cyc;
        logic [WN*DW-1:0] dat;
    } drsp_t;

    trsp_t tq[$];
    drsp_t dq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic obs_busy, obs_done;
    logic [NP-1:0] obs_dgnt;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [319:0] act,
                       input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mreset();
        for (int s = 0; s < SN; s++) begin
            for (int w = 0; w < WN; w++) begin
                m_tag[s][w] = '0;
                m_st[s][w]  = '0;
                m_vld[s][w] = 1'b0;
            end
        end
        t_ptr  = 0;
        d_ptr  = 0;
        fl_cnt = -1;
    endtask

    task automatic idle_in();
        flush_req_i   = 1'b0;
        tag_req_i     = '0;
        tag_we_i      = '0;
        tag_set_i     = '0;
        tag_way_en_i  = '0;
        tag_wtag_i    = '0;
        tag_wvalid_i  = '0;
        tag_wstate_i  = '0;
        tag_cmp_i     = '0;
        data_req_i    = '0;
        data_we_i     = '0;
        data_addr_i   = '0;
        data_way_en_i = '0;
        data_wdata_i  = '0;
        data_wstrb_i  = '0;
    endtask

    task automatic set_tag(input int p, input bit we, input int set,
                           input logic [WN-1:0] en, input logic [TW-1:0] t,
                           input bit v, input logic [1:0] st,
                           input logic [TW-1:0] cmp);
        tag_req_i[p]           = 1'b1;
        tag_we_i[p]            = we;
        tag_set_i[p*SW +: SW]  = SW'(set);
        tag_way_en_i[p*WN +: WN] = en;
        tag_wtag_i[p*TW +: TW] = t;
        tag_wvalid_i[p]        = v;
        tag_wstate_i[p*2 +: 2] = st;
        tag_cmp_i[p*TW +: TW]  = cmp;
    endtask

    task automatic set_data(input int p, input bit we, input int addr,
                            input logic [WN-1:0] en, input logic [DW-1:0] d,
                            input logic [SB-1:0] strb);
        data_req_i[p]             = 1'b1;
        data_we_i[p]              = we;
        data_addr_i[p*AW +: AW]   = AW'(addr);
        data_way_en_i[p*WN +: WN] = en;
        data_wdata_i[p*DW +: DW]  = d;
        data_wstrb_i[p*SB +: SB]  = strb;
    endtask

    // One clock of model: checks grants/flush flags, logs expected
    // responses, applies writes and flush effects.
    task automatic tick();
        logic [NP-1:0]    eg;
        logic [SN*WN-1:0] ecl;
        logic [WN-1:0]    en;
        logic [TW-1:0]    cmp;
        trsp_t            te;
        drsp_t            de;
        bit               busy, ok, found;
        int               tp, set, addr;
        #1;
        busy = (fl_cnt >= 0);
        obs_busy = flush_busy_o;
        obs_done = flush_done_o;
        obs_dgnt = data_gnt_o;
        chk("flush_busy", flush_busy_o, busy);
        chk("flush_done", flush_done_o, fl_cnt == SN);
        for (int s = 0; s < SN; s++)
            for (int w = 0; w < WN; w++)
                ecl[s*WN+w] = m_vld[s][w];
        chk("cl_valid", cl_valid_o, ecl);
        ok = !busy && !flush_req_i;

        eg = '0; found = 0; tp = 0;
        for (int k = 0; k < NP; k++) begin
            if (ok && !found && tag_req_i[(t_ptr + k) % NP]) begin
                found = 1; tp = (t_ptr + k) % NP; eg[tp] = 1'b1;
            end
        end
        chk("tag_gnt", tag_gnt_o, eg);
        if (found) begin
            t_ptr = (tp + 1) % NP;
            set = int'(tag_set_i[tp*SW +: SW]);
            en  = tag_way_en_i[tp*WN +: WN];
            if (tag_we_i[tp]) begin
                for (int w = 0; w < WN; w++) begin
                    if (en[w]) begin
                        m_tag[set][w] = tag_wtag_i[tp*TW +: TW];
                        m_st[set][w]  = tag_wstate_i[tp*2 +: 2];
                        m_vld[set][w] = tag_wvalid_i[tp];
                    end
                end
            end else begin
                cmp = tag_cmp_i[tp*TW +: TW];
                te.port = tp; te.cyc = cyc; te.en = en;
                te.tag = '0; te.vld = '0; te.st = '0; te.hit = '0;
                for (int w = 0; w < WN; w++) begin
                    if (en[w]) begin
                        te.tag[w*TW +: TW] = m_tag[set][w];
                        te.vld[w]          = m_vld[set][w];
                        te.st[w*2 +: 2]    = m_st[set][w];
                        te.hit[w] = m_vld[set][w] && (m_tag[set][w] == cmp);
                    end
                end
                tq.push_back(te);
            end
        end

        eg = '0; found = 0; tp = 0;
        for (int k = 0; k < NP; k++) begin
            if (ok && !found && data_req_i[(d_ptr + k) % NP]) begin
                found = 1; tp = (d_ptr + k) % NP; eg[tp] = 1'b1;
            end
        end
        chk("data_gnt", data_gnt_o, eg);
        if (found) begin
            d_ptr = (tp + 1) % NP;
            addr = int'(data_addr_i[tp*AW +: AW]);
            en   = data_way_en_i[tp*WN +: WN];
            if (data_we_i[tp]) begin
                for (int w = 0; w < WN; w++)
                    for (int b = 0; b < SB; b++)
                        if (en[w] && data_wstrb_i[tp*SB+b])
                            m_dat[w][addr][b*8 +: 8] =
                                data_wdata_i[tp*DW + b*8 +: 8];
            end else begin
                de.port = tp; de.cyc = cyc;
                for (int w = 0; w < WN; w++)
                    de.dat[w*DW +: DW] = m_dat[w][addr];
                dq.push_back(de);
            end
        end

        if (busy) begin
            if (fl_cnt == SN) fl_cnt = -1;
            else begin
                for (int w = 0; w < WN; w++) begin
                    m_vld[fl_cnt][w] = 1'b0;
                    m_st[fl_cnt][w]  = 2'b00;
                end
                fl_cnt++;
            end
        end else if (flush_req_i) begin
            fl_cnt = 0;
        end
        @(posedge clk_i); #1;
    endtask

    task automatic drain();
        idle_in();
        tick();
        tick();
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        trsp_t te;
        drsp_t de;
        logic [WN*TW-1:0] at;
        forever begin
            @(negedge clk_i);
            if (tag_rsp_valid_o != '0) begin
                if (tq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tag_rsp_spurious: got %b expected none",
                             tag_rsp_valid_o);
                end else begin
                    te = tq.pop_front();
                    at = tag_rtag_o;
                    for (int w = 0; w < WN; w++)
                        if (!te.en[w]) at[w*TW +: TW] = '0;
                    chk("tag_rsp",
                        {tag_rsp_valid_o, at, tag_rvalid_o,
                         tag_rstate_o, tag_hit_o},
                        {NP'(1 << te.port), te.tag, te.vld, te.st, te.hit});
                end
            end else if (tq.size() > 0 && tq[0].cyc < cyc) begin
                te = tq.pop_front();
                checks++; errors++;
                $display("FAIL tag_rsp_missing: got none expected port %0d",
                         te.port);
            end
            if (data_rsp_valid_o != '0) begin
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL data_rsp_spurious: got %b expected none",
                             data_rsp_valid_o);
                end else begin
                    de = dq.pop_front();
                    chk("data_rsp", {data_rsp_valid_o, data_rdata_o},
                        {NP'(1 << de.port), de.dat});
                end
            end else if (dq.size() > 0 && dq[0].cyc < cyc) begin
                de = dq.pop_front();
                checks++; errors++;
                $display("FAIL data_rsp_missing: got none expected port %0d",
                         de.port);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int n, bcnt, dcnt;
        bit got;
        idle_in();
        rst_i = 1'b0;
        mreset();
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_tag_gnt", tag_gnt_o, 0);
        chk("rst_data_gnt", data_gnt_o, 0);
        chk("rst_busy", flush_busy_o, 0);
        chk("rst_done", flush_done_o, 0);
        chk("rst_cl_valid", cl_valid_o, 0);
        chk("rst_tag_rsp", tag_rsp_valid_o, 0);
        chk("rst_data_rsp", data_rsp_valid_o, 0);
        chk("rst_rtag", tag_rtag_o, 0);
        chk("rst_rvalid", tag_rvalid_o, 0);
        chk("rst_rstate", tag_rstate_o, 0);
        chk("rst_hit", tag_hit_o, 0);
        chk("rst_rdata", data_rdata_o, 0);
        rst_i = 1'b1;
        tick();

        // Zero every data line in every way so all reads are known
        for (int a = 0; a < LN; a++) begin
            idle_in();
            set_data(0, 1, a, '1, '0, '1);
            tick();
        end
        drain();

        // Both ports read tags every cycle: grants alternate
        for (int i = 0; i < 6; i++) begin
            idle_in();
            set_tag(0, 0, i, '1, '0, 0, 0, '0);
            set_tag(1, 0, i + 1, '1, '0, 0, 0, '0);
            tick();
        end
        drain();

        // Tag write then hit lookup from the other port
        idle_in();
        set_tag(0, 1, 5, 4'b0100, 20'h12345, 1, 2'd2, '0);
        tick();
        idle_in();
        set_tag(1, 0, 5, 4'b1111, '0, 0, 0, 20'h12345);
        tick();
        idle_in();
        chk("hit_set5", tag_hit_o, 4'b0100);
        chk("state_w2", tag_rstate_o[5:4], 2'd2);
        tick();
        drain();

        // Byte-strobed data write then read-back
        idle_in();
        set_data(0, 1, 3*BT + 7, 4'b0010, '1, 8'h0F);
        tick();
        idle_in();
        set_data(1, 0, 3*BT + 7, '1, '0, '0);
        tick();
        idle_in();
        chk("strb_w1", data_rdata_o[DW +: DW], 64'h0000_0000_FFFF_FFFF);
        tick();
        drain();

        // Fill all sets, then flush
        for (int s = 0; s < SN; s++) begin
            idle_in();
            set_tag(s % NP, 1, s, '1, TW'($urandom),
                    1, 2'($urandom_range(1, 3)), '0);
            tick();
        end
        idle_in();
        flush_req_i = 1'b1;
        tick();
        idle_in();
        bcnt = 0; dcnt = 0;
        for (int i = 0; i < SN + 4; i++) begin
            tick();
            bcnt += int'(obs_busy);
            dcnt += int'(obs_done);
        end
        chk("flush_busy_cycles", bcnt, SN + 1);
        chk("flush_done_pulses", dcnt, 1);
        for (int s = 0; s < SN; s++) begin
            idle_in();
            set_tag(s % NP, 0, s, '1, '0, 0, 0, TW'($urandom));
            tick();
        end
        drain();

        // Flush together with a data read request
        idle_in();
        set_data(1, 0, 9, '1, '0, '0);
        flush_req_i = 1'b1;
        got = 0; n = 0;
        for (int i = 1; i <= SN + 8; i++) begin
            if (!got) begin
                tick();
                flush_req_i = 1'b0;
                if (obs_dgnt != '0) begin
                    got = 1; n = i;
                    idle_in();
                end
            end
        end
        chk("gnt_after_done", n, SN + 3);
        drain();

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 3000; i++) begin
            idle_in();
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 2) != 0)
                    set_tag(p, $urandom_range(0, 2) == 0,
                            $urandom_range(0, 7), WN'($urandom),
                            TW'($urandom_range(0, 3)),
                            $urandom_range(0, 3) != 0,
                            2'($urandom), TW'($urandom_range(0, 3)));
                if ($urandom_range(0, 2) != 0)
                    set_data(p, $urandom_range(0, 1) == 0,
                             $urandom_range(0, 4*BT - 1), WN'($urandom),
                             {$urandom, $urandom}, SB'($urandom));
            end
            flush_req_i = ($urandom_range(0, 299) == 0);
            tick();
        end
        idle_in();
        for (int i = 0; i < SN + 4; i++) tick();

        // Reset while the flush walk is at cnt=10
        for (int s = 0; s < 16; s++) begin
            idle_in();
            set_tag(0, 1, s, '1, TW'($urandom), 1, 2'd3, '0);
            tick();
        end
        idle_in();
        flush_req_i = 1'b1;
        tick();
        idle_in();
        for (int i = 0; i < 10; i++) tick();
        rst_i = 1'b0;
        #1;
        chk("rst_mid_busy", flush_busy_o, 0);
        chk("rst_mid_cl_valid", cl_valid_o, 0);
        mreset();
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        tick();
        for (int s = 0; s < SN; s++) begin
            idle_in();
            set_tag(s % NP, 0, s, '1, '0, 0, 0, '0);
            tick();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
